// File: rtl/tns_decoder_03.sv
// Receive-side TNS decoder: a two-stage pipeline that rebuilds the data value as a weighted
// sum of the 3-bit codeword and flags adjacent-wire opposite transitions between valid words.
module tns_decoder_03 #(
  parameter int DLEN = 3,
  parameter int WA   = 3,
  parameter int WB   = 2,
  parameter int CNTW = 8
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic [2:0]      codein,
  input  logic            valid_in,
  input  logic            clr_count,
  output logic [DLEN-1:0] dataout,
  output logic            valid_out,
  output logic            xt_flag,
  output logic [CNTW-1:0] xt_count
);

  localparam logic [DLEN-1:0] W_A = DLEN'(WA);
  localparam logic [DLEN-1:0] W_B = DLEN'(WB);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [2:0]      r_s1_code;
  logic            r_s1_v;
  logic [2:0]      r_prev_code;
  logic            r_prev_v;
  logic [DLEN-1:0] r_dataout;
  logic            r_valid_out;
  logic            r_xt_flag;
  logic [CNTW-1:0] r_xt_count;

  logic [DLEN-1:0] w_sum;
  logic            w_flag;
  logic [CNTW-1:0] w_count_next;

  // A wire pair toggles in opposite directions when it goes 01->10 or 10->01.
  function automatic logic f_pair_xt(input logic [1:0] p, input logic [1:0] c);
    return ((p == 2'b01) && (c == 2'b10)) || ((p == 2'b10) && (c == 2'b01));
  endfunction

  function automatic logic f_violation(input logic [2:0] p, input logic [2:0] c);
    return f_pair_xt(p[2:1], c[2:1]) | f_pair_xt(p[1:0], c[1:0]);
  endfunction

  // Weighted decode, crosstalk detection and next counter value for the word in S1.
  always_comb begin
    w_sum        = {DLEN{1'b0}};
    w_flag       = 1'b0;
    w_count_next = r_xt_count;
    w_sum = (r_s1_code[2] ? W_A : {DLEN{1'b0}})
          + (r_s1_code[1] ? W_B : {DLEN{1'b0}})
          + {{(DLEN-1){1'b0}}, r_s1_code[0]};
    w_flag = r_s1_v & r_prev_v & f_violation(r_prev_code, r_s1_code);
    if (clr_count) begin
      w_count_next = {CNTW{1'b0}};
    end else if (w_flag && (r_xt_count != CNT_MAX)) begin
      w_count_next = r_xt_count + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      w_count_next = r_xt_count;
    end
  end

  // Input capture stage.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_code <= 3'b000;
      r_s1_v    <= 1'b0;
    end else begin
      r_s1_code <= codein;
      r_s1_v    <= valid_in;
    end
  end

  // Output stage; bubbles keep dataout and the comparison reference unchanged.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_dataout   <= {DLEN{1'b0}};
      r_valid_out <= 1'b0;
      r_xt_flag   <= 1'b0;
      r_prev_code <= 3'b000;
      r_prev_v    <= 1'b0;
    end else if (r_s1_v) begin
      r_dataout   <= w_sum;
      r_valid_out <= 1'b1;
      r_xt_flag   <= w_flag;
      r_prev_code <= r_s1_code;
      r_prev_v    <= 1'b1;
    end else begin
      r_valid_out <= 1'b0;
      r_xt_flag   <= 1'b0;
    end
  end

  // Saturating violation counter; clear wins over a same-edge increment.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_xt_count <= {CNTW{1'b0}};
    end else begin
      r_xt_count <= w_count_next;
    end
  end

  assign dataout   = r_dataout;
  assign valid_out = r_valid_out;
  assign xt_flag   = r_xt_flag;
  assign xt_count  = r_xt_count;

endmodule

// File: tb/tb_tns_decoder_03.sv
// Bench for tns_decoder_03: a default instance and a small-counter / alternate-weight instance
// share stimulus and are compared every cycle against a behavioural model.
module tb_tns_decoder_03;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] codein = 3'b000;
  logic       valid_in = 1'b0;
  logic       clr_count = 1'b0;

  logic [2:0] d0; logic v0; logic f0; logic [7:0] c0;
  logic [3:0] d1; logic v1; logic f1; logic [1:0] c1;

  int checks = 0;
  int errors = 0;

  tns_decoder_03 u_dut0 (
    .clock(clock), .rst_n(rst_n), .codein(codein), .valid_in(valid_in), .clr_count(clr_count),
    .dataout(d0), .valid_out(v0), .xt_flag(f0), .xt_count(c0)
  );

  tns_decoder_03 #(.DLEN(4), .WA(5), .WB(3), .CNTW(2)) u_dut1 (
    .clock(clock), .rst_n(rst_n), .codein(codein), .valid_in(valid_in), .clr_count(clr_count),
    .dataout(d1), .valid_out(v1), .xt_flag(f1), .xt_count(c1)
  );

  always #5 clock = ~clock;

  // Behavioural model: word captured at one edge emerges at the next.
  int wa_t[2] = '{3, 5};
  int wb_t[2] = '{2, 3};
  int cmax[2] = '{255, 3};
  int m_data[2], m_vout[2], m_flag[2], m_cnt[2], m_prevc[2], m_prevv[2];
  int m_pv, m_pc;

  function automatic int dec(input int c, input int i);
    return ((c >> 2) & 1) * wa_t[i] + ((c >> 1) & 1) * wb_t[i] + (c & 1);
  endfunction

  function automatic int viol(input int p, input int c);
    int r = 0;
    for (int k = 0; k < 2; k++) begin
      int pp = (p >> k) & 3;
      int cc = (c >> k) & 3;
      if ((pp == 1 || pp == 2) && (cc == 3 - pp)) r = 1;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_data[i] = 0; m_vout[i] = 0; m_flag[i] = 0; m_cnt[i] = 0; m_prevc[i] = 0; m_prevv[i] = 0;
    end
    m_pv = 0; m_pc = 0;
  endtask

  task automatic model_edge(input int v, input int c, input int clr);
    for (int i = 0; i < 2; i++) begin
      if (m_pv != 0) begin
        m_flag[i]  = (viol(m_prevc[i], m_pc) != 0 && m_prevv[i] != 0) ? 1 : 0;
        m_data[i]  = dec(m_pc, i);
        m_vout[i]  = 1;
        m_prevc[i] = m_pc;
        m_prevv[i] = 1;
      end else begin
        m_vout[i] = 0;
        m_flag[i] = 0;
      end
      if (clr != 0) m_cnt[i] = 0;
      else if (m_flag[i] != 0 && m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
    end
    m_pv = v; m_pc = c;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("d0_data",  {29'd0, d0}, m_data[0]);
    chk("d0_valid", {31'd0, v0}, m_vout[0]);
    chk("d0_flag",  {31'd0, f0}, m_flag[0]);
    chk("d0_count", {24'd0, c0}, m_cnt[0]);
    chk("d1_data",  {28'd0, d1}, m_data[1]);
    chk("d1_valid", {31'd0, v1}, m_vout[1]);
    chk("d1_flag",  {31'd0, f1}, m_flag[1]);
    chk("d1_count", {30'd0, c1}, m_cnt[1]);
  endtask

  task automatic cyc(input logic v, input logic [2:0] c, input logic clr);
    valid_in = v; codein = c; clr_count = clr;
    @(posedge clock);
    if (rst_n) model_edge(int'(v), int'(c), int'(clr));
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int k = 0; k < n; k++) cyc(1'($urandom), 3'($urandom), 1'($urandom));
    rst_n = 1'b1;
  endtask

  int sweep_d0[8] = '{0, 1, 2, 3, 3, 4, 5, 6};
  int sweep_f0[8] = '{0, 0, 1, 0, 1, 0, 1, 0};
  int sat_c1[6]   = '{0, 1, 2, 3, 3, 3};
  logic [2:0] alt;
  int base;

  initial begin
    model_reset();
    // Reset held with random inputs, then idle.
    for (int k = 0; k < 3; k++) cyc(1'($urandom), 3'($urandom), 1'($urandom));
    chk("reset_valid", {31'd0, v0}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cyc(1'b0, 3'($urandom), 1'b0);

    // Sweep of all codes back to back.
    for (int k = 0; k < 9; k++) begin
      cyc(k < 8, 3'(k), 1'b0);
      if (k >= 1) begin
        chk("sweep_data", {29'd0, d0}, sweep_d0[k-1]);
        chk("sweep_flag", {31'd0, f0}, sweep_f0[k-1]);
      end
    end
    chk("sweep_count", {24'd0, c0}, 32'd3);
    chk("weight_111", {28'd0, d1}, 32'd9);

    // Bubbles between 010 and 101.
    base = int'(c0);
    cyc(1'b1, 3'b010, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 3'b000, 1'b0);
      chk("bubble_hold", {29'd0, d0}, 32'd2);
    end
    cyc(1'b1, 3'b101, 1'b0);
    cyc(1'b0, 3'b000, 1'b0);
    chk("bubble_data", {29'd0, d0}, 32'd4);
    chk("bubble_flag", {31'd0, f0}, 32'd1);
    chk("bubble_count", {24'd0, c0}, base + 1);

    // Saturation on the 2-bit counter, then clear against a flagged word.
    do_reset(1);
    for (int k = 0; k < 7; k++) begin
      alt = (k % 2 == 0) ? 3'b010 : 3'b101;
      cyc(1'b1, alt, 1'b0);
      if (k >= 1) chk("sat_count", {30'd0, c1}, sat_c1[k-1]);
    end
    cyc(1'b0, 3'b000, 1'b1);
    chk("clr_count", {30'd0, c1}, 32'd0);
    chk("clr_flag", {31'd0, f1}, 32'd1);

    // Reset between two words.
    cyc(1'b1, 3'b001, 1'b0);
    do_reset(1);
    cyc(1'b1, 3'b010, 1'b0);
    chk("mid_rst_valid", {31'd0, v0}, 32'd0);
    cyc(1'b0, 3'b000, 1'b0);
    chk("mid_rst_data", {29'd0, d0}, 32'd2);
    chk("mid_rst_flag", {31'd0, f0}, 32'd0);

    // Weights 111, 100, 011 on the alternate instance.
    cyc(1'b1, 3'b111, 1'b0);
    cyc(1'b1, 3'b100, 1'b0);
    chk("weight_a", {28'd0, d1}, 32'd9);
    cyc(1'b1, 3'b011, 1'b0);
    chk("weight_b", {28'd0, d1}, 32'd5);
    cyc(1'b0, 3'b000, 1'b0);
    chk("weight_c", {28'd0, d1}, 32'd4);

    // Randomized traffic with occasional clears and resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0) do_reset(int'($urandom_range(1, 2)));
      else cyc($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
